// File: rtl/calc_op_sequencer.sv
// Control sequencer for a 4-digit hex calculator: keypad entry, left-to-right add/sub,
// and a start/done handshake to a shared multi-cycle multiplier.
module calc_op_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               newkey,
    input  logic [4:0]         keycode,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic [WIDTH-1:0]   valueOutput,
    output logic               overflow,
    output logic               busy
);

    localparam int DIGITS = WIDTH / 4;
    localparam int CW     = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [4:0] KEY_ADD  = 5'h10;
    localparam logic [4:0] KEY_SUB  = 5'h11;
    localparam logic [4:0] KEY_MUL  = 5'h12;
    localparam logic [4:0] KEY_EQ   = 5'h13;
    localparam logic [4:0] KEY_CLR  = 5'h14;
    localparam logic [4:0] KEY_BKSP = 5'h15;

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MUL_WAIT = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_MUL  = 2'd3
    } op_t;

    state_t            state_q, state_d;
    op_t               pend_q, pend_d;
    op_t               nextop_q, nextop_d;
    op_t               key_op_s;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  entry_q, entry_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              clr_pend_q, clr_pend_d;
    logic              mul_start_q, mul_start_d;
    logic [WIDTH-1:0]  mul_a_q, mul_a_d;
    logic [WIDTH-1:0]  mul_b_q, mul_b_d;
    logic [WIDTH-1:0]  value_q, value_d;
    logic              busy_q, busy_d;
    logic [WIDTH:0]    sum_s;
    logic [WIDTH:0]    diff_s;
    logic              clear_s;
    logic              launch_s;

    assign sum_s  = {1'b0, acc_q} + {1'b0, entry_q};
    assign diff_s = {1'b0, acc_q} - {1'b0, entry_q};

    // Operator keycode decode; EQ and non-operators map to NONE
    always_comb begin
        case (keycode)
            KEY_ADD: key_op_s = OP_ADD;
            KEY_SUB: key_op_s = OP_SUB;
            KEY_MUL: key_op_s = OP_MUL;
            default: key_op_s = OP_NONE;
        endcase
    end

    // Next-state logic for the sequencer and all datapath registers
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        nextop_d    = nextop_q;
        acc_d       = acc_q;
        entry_d     = entry_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        clr_pend_d  = clr_pend_q;
        mul_start_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        clear_s     = 1'b0;
        launch_s    = 1'b0;

        case (state_q)
            ST_ENTRY: begin
                if (clr_pend_q) begin
                    // A CLR that arrived during EXEC lands here; a key this cycle is dropped
                    clear_s    = 1'b1;
                    clr_pend_d = 1'b0;
                end else if (newkey) begin
                    if (keycode < KEY_ADD) begin
                        if (count_q < CNT_MAX) begin
                            entry_d = {entry_q[WIDTH-5:0], keycode[3:0]};
                            count_d = count_q + CNT_ONE;
                        end else begin
                            entry_d = entry_q;
                        end
                    end else begin
                        case (keycode)
                            KEY_ADD, KEY_SUB, KEY_MUL: begin
                                if (count_q == '0) begin
                                    pend_d = key_op_s;
                                end else begin
                                    launch_s = 1'b1;
                                end
                            end
                            KEY_EQ:   launch_s = (count_q != '0);
                            KEY_CLR:  clear_s  = 1'b1;
                            KEY_BKSP: begin
                                if (count_q != '0) begin
                                    entry_d = entry_q >> 4;
                                    count_d = count_q - CNT_ONE;
                                end else begin
                                    entry_d = entry_q;
                                end
                            end
                            default: launch_s = 1'b0;
                        endcase
                    end
                end else begin
                    state_d = ST_ENTRY;
                end

                if (launch_s) begin
                    nextop_d = key_op_s;
                    if (pend_q == OP_MUL) begin
                        state_d     = ST_MUL_WAIT;
                        mul_start_d = 1'b1;
                        mul_a_d     = acc_q;
                        mul_b_d     = entry_q;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else begin
                    nextop_d = nextop_q;
                end
            end

            ST_EXEC: begin
                case (pend_q)
                    OP_NONE: acc_d = entry_q;
                    OP_ADD: begin
                        acc_d = sum_s[WIDTH-1:0];
                        ovf_d = ovf_q | sum_s[WIDTH];
                    end
                    OP_SUB: begin
                        acc_d = diff_s[WIDTH-1:0];
                        ovf_d = ovf_q | diff_s[WIDTH];
                    end
                    default: acc_d = acc_q;
                endcase
                pend_d  = nextop_q;
                entry_d = '0;
                count_d = '0;
                state_d = ST_ENTRY;
                if (newkey && (keycode == KEY_CLR)) begin
                    clr_pend_d = 1'b1;
                end else begin
                    clr_pend_d = clr_pend_q;
                end
            end

            ST_MUL_WAIT: begin
                if (mul_done) begin
                    acc_d   = mul_product[WIDTH-1:0];
                    ovf_d   = ovf_q | (|mul_product[2*WIDTH-1:WIDTH]);
                    pend_d  = nextop_q;
                    entry_d = '0;
                    count_d = '0;
                    state_d = ST_ENTRY;
                end else if (newkey && (keycode == KEY_CLR)) begin
                    clear_s = 1'b1;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_MUL_WAIT;
                end
            end

            ST_DRAIN: begin
                // Multiplier is still running: swallow its product before accepting new work
                if (mul_done) begin
                    state_d = ST_ENTRY;
                end else if (newkey && (keycode == KEY_CLR)) begin
                    clear_s = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end

            default: state_d = ST_ENTRY;
        endcase

        if (clear_s) begin
            acc_d   = '0;
            entry_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            pend_d  = OP_NONE;
        end else begin
            pend_d = pend_d;
        end

        value_d = ((state_d == ST_ENTRY) && (count_d != '0)) ? entry_d : acc_d;
        busy_d  = (state_d != ST_ENTRY);
    end

    // State and registered-output update
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ENTRY;
            pend_q      <= OP_NONE;
            nextop_q    <= OP_NONE;
            acc_q       <= '0;
            entry_q     <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            clr_pend_q  <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            value_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            nextop_q    <= nextop_d;
            acc_q       <= acc_d;
            entry_q     <= entry_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            clr_pend_q  <= clr_pend_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            value_q     <= value_d;
            busy_q      <= busy_d;
        end
    end

    assign mul_start   = mul_start_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign valueOutput = value_q;
    assign overflow    = ovf_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer: directed calculator scenarios plus random key
// streams checked against an arithmetic model of the calculator.
module tb_calc_op_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        newkey = 1'b0;
    logic [4:0]  keycode = 5'h00;
    logic        mul_start;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_done = 1'b0;
    logic [31:0] mul_product = 32'h0;
    logic [15:0] valueOutput;
    logic        overflow;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int mul_delay = 5;
    int mul_starts = 0;
    int busy_cycles = 0;

    logic [15:0] exp_val_q[$];
    logic        exp_ovf_q[$];
    logic [15:0] exp_a_q[$];
    logic [15:0] exp_b_q[$];

    // calculator model state
    longint m_acc = 0, m_entry = 0, m_cnt = 0;
    int     m_pend = 0;
    bit     m_ovf = 1'b0;

    calc_op_sequencer #(.WIDTH(16)) dut (
        .clock(clock), .reset(reset), .newkey(newkey), .keycode(keycode),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_product(mul_product),
        .valueOutput(valueOutput), .overflow(overflow), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = 0; m_entry = 0; m_cnt = 0; m_pend = 0; m_ovf = 1'b0;
    endtask

    task automatic model_apply(input int nxt);
        longint r;
        case (m_pend)
            0: m_acc = m_entry;
            1: begin r = m_acc + m_entry; if (r > 65535) m_ovf = 1'b1; m_acc = r % 65536; end
            2: begin if (m_acc < m_entry) m_ovf = 1'b1; m_acc = (m_acc + 65536 - m_entry) % 65536; end
            default: begin
                exp_a_q.push_back(16'(m_acc));
                exp_b_q.push_back(16'(m_entry));
                r = m_acc * m_entry;
                if (r > 65535) m_ovf = 1'b1;
                m_acc = r % 65536;
            end
        endcase
        m_pend = nxt; m_entry = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic [4:0] k);
        if (k < 5'h10) begin
            if (m_cnt < 4) begin m_entry = (m_entry * 16 + longint'(k)) % 65536; m_cnt++; end
        end else begin
            case (k)
                5'h10, 5'h11, 5'h12: begin
                    if (m_cnt == 0) m_pend = int'(k) - 15;
                    else model_apply(int'(k) - 15);
                end
                5'h13: if (m_cnt > 0) model_apply(0);
                5'h14: model_clear();
                5'h15: if (m_cnt > 0) begin m_entry = m_entry / 16; m_cnt--; end
                default: ;
            endcase
        end
    endtask

    function automatic logic [15:0] model_disp();
        return (m_cnt > 0) ? 16'(m_entry) : 16'(m_acc);
    endfunction

    task automatic push_exp(input logic [15:0] v, input logic o);
        exp_val_q.push_back(v);
        exp_ovf_q.push_back(o);
    endtask

    task automatic send(input logic [4:0] k);
        @(negedge clock);
        newkey = 1'b1; keycode = k;
        @(negedge clock);
        newkey = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin @(negedge clock); n++; end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic key(input logic [4:0] k);
        model_step(k);
        push_exp(model_disp(), m_ovf);
        send(k);
        wait_idle();
    endtask

    // Response monitor: after each accepted key, compare once the DUT is idle again
    initial begin
        forever begin
            @(posedge clock);
            if (newkey && !reset) begin
                int n;
                n = 0;
                @(negedge clock);
                while (busy && n < 300) begin @(negedge clock); n++; end
                if (busy) chk("resp_timeout", 32'(busy), 32'd0);
                if (exp_val_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL sb_underflow: got a response, expected none queued");
                end else begin
                    chk("sb_value", 32'(valueOutput), 32'(exp_val_q.pop_front()));
                    chk("sb_overflow", 32'(overflow), 32'(exp_ovf_q.pop_front()));
                end
            end
        end
    end

    // Multiplier request monitor
    always @(negedge clock) begin
        if (mul_start) begin
            mul_starts++;
            if (exp_a_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL mul_unexpected: got mul_start a=0x%0h b=0x%0h, expected none", mul_a, mul_b);
            end else begin
                chk("mul_a", 32'(mul_a), 32'(exp_a_q.pop_front()));
                chk("mul_b", 32'(mul_b), 32'(exp_b_q.pop_front()));
            end
        end
    end

    always @(negedge clock) if (busy) busy_cycles++;

    // Multiplier model with configurable latency (0 = random)
    initial begin
        forever begin
            @(negedge clock);
            if (mul_start) begin
                logic [15:0] a, b;
                int d;
                a = mul_a; b = mul_b;
                d = (mul_delay == 0) ? int'($urandom_range(1, 10)) : mul_delay;
                repeat (d) @(negedge clock);
                mul_product = {16'h0, a} * {16'h0, b};
                mul_done = 1'b1;
                @(negedge clock);
                mul_done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, b0, r;
        logic [4:0] k;

        repeat (2) @(negedge clock);
        chk("rst_value", 32'(valueOutput), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mul_start", 32'(mul_start), 32'd0);
        reset = 1'b0;

        // 1 2 ADD 3 4 EQ
        b0 = busy_cycles;
        key(5'h1); key(5'h2); key(5'h10); key(5'h3); key(5'h4); key(5'h13);
        chk("t1_value", 32'(valueOutput), 32'h46);
        chk("t1_overflow", 32'(overflow), 32'd0);
        chk("t1_busy_cycles", 32'(busy_cycles - b0), 32'd2);

        // 2 MUL 3 ADD 4 EQ, multiplier latency 5
        key(5'h14);
        s0 = mul_starts;
        key(5'h2); key(5'h12); key(5'h3); key(5'h10); key(5'h4); key(5'h13);
        chk("t2_value", 32'(valueOutput), 32'h000A);
        chk("t2_mul_starts", 32'(mul_starts - s0), 32'd1);

        // 0x100 * 0x100 overflows to zero
        key(5'h14);
        key(5'h1); key(5'h0); key(5'h0); key(5'h12); key(5'h1); key(5'h0); key(5'h0); key(5'h13);
        chk("t3_value", 32'(valueOutput), 32'h0);
        chk("t3_overflow", 32'(overflow), 32'd1);
        key(5'h14);
        chk("t3_clr_value", 32'(valueOutput), 32'h0);
        chk("t3_clr_overflow", 32'(overflow), 32'd0);

        // 3 SUB 5 EQ, then digit limit and backspace
        key(5'h3); key(5'h11); key(5'h5); key(5'h13);
        chk("t4_value", 32'(valueOutput), 32'hFFFE);
        chk("t4_overflow", 32'(overflow), 32'd1);
        key(5'h1); key(5'h2); key(5'h3); key(5'h4); key(5'h5);
        chk("t4_digits", 32'(valueOutput), 32'h1234);
        key(5'h15);
        chk("t4_bksp", 32'(valueOutput), 32'h0123);

        // CLR during MUL_WAIT, product arrives 20 cycles later; digits in DRAIN dropped
        key(5'h14);
        key(5'h2); key(5'h12); key(5'h3);
        mul_delay = 20;
        model_step(5'h13);
        model_step(5'h14);
        push_exp(16'h0, 1'b0);
        s0 = mul_starts;
        send(5'h13);
        repeat (3) @(negedge clock);
        send(5'h14);
        send(5'h7);
        chk("t5_drain_busy", 32'(busy), 32'd1);
        wait_idle();
        @(negedge clock);
        chk("t5_mul_starts", 32'(mul_starts - s0), 32'd1);
        chk("t5_value", 32'(valueOutput), 32'h0);

        // Reset during MUL_WAIT; the late product must be ignored
        key(5'h2); key(5'h12); key(5'h3);
        model_step(5'h13);
        model_clear();
        push_exp(16'h0, 1'b0);
        send(5'h13);
        repeat (4) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_value", 32'(valueOutput), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_mul_a", 32'(mul_a), 32'h0);
        chk("t6_rst_mul_b", 32'(mul_b), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        repeat (25) @(negedge clock);
        chk("t6_late_value", 32'(valueOutput), 32'h0);
        chk("t6_late_overflow", 32'(overflow), 32'd0);
        chk("t6_late_busy", 32'(busy), 32'd0);
        key(5'h5);
        chk("t6_after", 32'(valueOutput), 32'h5);

        // Random key streams with random multiplier latency
        mul_delay = 0;
        key(5'h14);
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55)      k = 5'($urandom_range(0, 15));
            else if (r < 63) k = 5'h10;
            else if (r < 70) k = 5'h11;
            else if (r < 78) k = 5'h12;
            else if (r < 88) k = 5'h13;
            else if (r < 92) k = 5'h15;
            else if (r < 95) k = 5'h14;
            else             k = 5'($urandom_range(22, 31));
            key(k);
        end

        repeat (30) @(negedge clock);
        chk("sb_leftover", 32'(exp_val_q.size()), 32'd0);
        chk("mul_leftover", 32'(exp_a_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
